// File: rtl/cpu_types_pkg.sv
// Shared types for the multicore MIPS memory side: data word, RAM handshake
// state, and the dual-core arbiter's FSM state and LL/SC link record.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE,
        SERVE0,
        SERVE1,
        SCFAIL0,
        SCFAIL1
    } arb_state_t;

    typedef struct packed {
        logic  valid;
        word_t addr;
    } link_t;

    // Address equality ignoring the bits below lsb (word-granular link match).
    function automatic logic addr_match(input word_t a, input word_t b, input int lsb);
        return (a >> lsb) == (b >> lsb);
    endfunction

endpackage

// File: rtl/dual_core_mem_arb_link_reg.sv
// One core's LL/SC link register: set by a completed LL, cleared by a failed
// SC or by any completed write that hits the linked word.
module link_reg
    import cpu_types_pkg::*;
#(
    parameter int ADDR_CMP_LSB = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  set,
    input  word_t set_addr,
    input  logic  snoop_wen,
    input  word_t snoop_addr,
    input  logic  clr,
    input  word_t probe_addr,
    output logic  match
);

    link_t link;
    logic  snoop_hit;

    assign snoop_hit = snoop_wen && link.valid && addr_match(link.addr, snoop_addr, ADDR_CMP_LSB);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link <= '0;
        end else if (clr || snoop_hit) begin
            link.valid <= 1'b0;
        end else if (set) begin
            link <= '{valid: 1'b1, addr: set_addr};
        end
    end

    assign match = link.valid && addr_match(link.addr, probe_addr, ADDR_CMP_LSB);

endmodule

// File: rtl/dual_core_mem_arb.sv
// Round-robin arbiter sharing one RAM data port between two dcaches, with
// per-core LL/SC link tracking so SC returns success (1) or failure (0).
module dual_core_mem_arb
    import cpu_types_pkg::*;
#(
    parameter int NCORES       = 2,
    parameter int ADDR_CMP_LSB = 2
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic      [1:0] dREN,
    input  logic      [1:0] dWEN,
    input  logic      [1:0] datomic,
    input  word_t     [1:0] daddr,
    input  word_t     [1:0] dstore,
    output logic      [1:0] dwait,
    output word_t     [1:0] dload,
    output logic            ramREN,
    output logic            ramWEN,
    output word_t           ramaddr,
    output word_t           ramstore,
    input  word_t           ramload,
    input  ramstate_t       ramstate
);

    arb_state_t state, next_state;
    logic       prio, flip_prio;
    logic       grant, cur;
    logic [1:0] req, is_sc, is_ll;
    logic [1:0] link_match, link_set, link_clr;
    logic       snoop_wen;
    word_t      snoop_addr;

    // dREN together with dWEN is illegal; the write wins.
    assign req   = dREN | dWEN;
    assign is_sc = datomic & dWEN;
    assign is_ll = datomic & dREN & ~dWEN;

    assign grant = (req == 2'b11) ? prio : req[1];
    assign cur   = (state == SERVE1) || (state == SCFAIL1);

    for (genvar n = 0; n < 2; n++) begin : g_link
        link_reg #(
            .ADDR_CMP_LSB(ADDR_CMP_LSB)
        ) u_link (
            .clk       (CLK),
            .rst_n     (nRST),
            .set       (link_set[n]),
            .set_addr  (daddr[n]),
            .snoop_wen (snoop_wen),
            .snoop_addr(snoop_addr),
            .clr       (link_clr[n]),
            .probe_addr(daddr[n]),
            .match     (link_match[n])
        );
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            prio <= 1'b0;
        end else if (flip_prio) begin
            prio <= ~prio;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (|req) begin
                    if (is_sc[grant] && !link_match[grant]) begin
                        next_state = grant ? SCFAIL1 : SCFAIL0;
                    end else begin
                        next_state = grant ? SERVE1 : SERVE0;
                    end
                end
            end
            SERVE0, SERVE1: begin
                if (!req[cur] || ramstate == ACCESS) begin
                    next_state = IDLE;
                end
            end
            SCFAIL0, SCFAIL1: next_state = IDLE;
            default:          next_state = IDLE;
        endcase
    end

    always_comb begin
        dwait      = 2'b11;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        link_set   = '0;
        link_clr   = '0;
        snoop_wen  = 1'b0;
        snoop_addr = daddr[cur];
        flip_prio  = 1'b0;
        case (state)
            SERVE0, SERVE1: begin
                if (req[cur]) begin
                    ramWEN   = dWEN[cur];
                    ramREN   = dREN[cur] & ~dWEN[cur];
                    ramaddr  = daddr[cur];
                    ramstore = dstore[cur];
                    // ERROR keeps the enables up and simply retries.
                    if (ramstate == ACCESS) begin
                        dwait[cur]     = 1'b0;
                        dload[cur]     = is_sc[cur] ? word_t'(1) : ramload;
                        flip_prio      = 1'b1;
                        link_set[cur]  = is_ll[cur];
                        snoop_wen      = dWEN[cur];
                    end
                end
            end
            SCFAIL0, SCFAIL1: begin
                dwait[cur]    = 1'b0;
                link_clr[cur] = 1'b1;
                flip_prio     = 1'b1;
            end
            default: ;
        endcase
    end

    a_ncores : assert property (@(posedge CLK) NCORES == 2);
    a_no_rw  : assert property (@(posedge CLK) disable iff (!nRST) !(|(dREN & dWEN)));

endmodule

// File: tb/tb_dual_core_mem_arb.sv
// Scoreboard bench for dual_core_mem_arb: a small RAM responder model, per-core
// expected-completion queues, and directed LL/SC/arbitration scenarios.
module tb_dual_core_mem_arb;
    import cpu_types_pkg::*;

    logic            CLK = 1'b0;
    logic            nRST;
    logic      [1:0] dREN, dWEN, datomic;
    word_t     [1:0] daddr, dstore;
    logic      [1:0] dwait;
    word_t     [1:0] dload;
    logic            ramREN, ramWEN;
    word_t           ramaddr, ramstore, ramload;
    ramstate_t       ramstate;

    dual_core_mem_arb #(
        .NCORES      (2),
        .ADDR_CMP_LSB(2)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .datomic (datomic),
        .daddr   (daddr),
        .dstore  (dstore),
        .dwait   (dwait),
        .dload   (dload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        word_t load;
        word_t addr;
        bit    chk_load;
        bit    fail;
    } exp_t;

    exp_t  sb0[$];
    exp_t  sb1[$];
    int    done_cnt[2] = '{0, 0};
    int    done_log[$];
    int    n_checks = 0;
    int    n_pass = 0;
    word_t mem[word_t];
    int    wr_cnt = 0;
    int    busy_n = 0;
    int    err_n = 0;
    int    rcnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    // RAM responder: per transaction, err_n ERROR cycles, busy_n BUSY cycles, then ACCESS.
    always @(posedge CLK) begin
        #2;
        if (ramREN || ramWEN) begin
            if (rcnt < err_n) ramstate = ERROR;
            else if (rcnt < err_n + busy_n) ramstate = BUSY;
            else ramstate = ACCESS;
            ramload = mem.exists(ramaddr) ? mem[ramaddr] : '0;
            rcnt++;
        end else begin
            ramstate = FREE;
            rcnt = 0;
        end
    end

    task automatic mon_core(input bit c);
        exp_t e;
        bit   have;
        if (dwait[c] === 1'b0) begin
            have = 1'b0;
            if (c == 1'b0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
            if (c == 1'b1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
            check($sformatf("done_expected_c%0d", c), 32'(have), 32'd1);
            if (have) begin
                if (e.chk_load) check($sformatf("dload_c%0d", c), dload[c], e.load);
                if (e.fail) check($sformatf("scfail_no_ram_c%0d", c), 32'({ramREN, ramWEN}), 32'd0);
                else check($sformatf("ramaddr_c%0d", c), ramaddr, e.addr);
            end
            done_cnt[c]++;
            done_log.push_back(int'(c));
        end else begin
            check($sformatf("waiting_dload_c%0d", c), dload[c], 32'd0);
        end
    endtask

    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            for (int i = 0; i < 2; i++) mon_core(1'(i));
            if (ramstate == ACCESS && ramWEN) begin
                mem[ramaddr] = ramstore;
                wr_cnt++;
            end
        end
    end

    task automatic op(input bit c, input bit ren, input bit wen, input bit atm,
                      input word_t addr, input word_t data, input word_t exp_load,
                      input bit chk_load, input bit fail, output int cyc);
        exp_t e;
        int   start;
        e.load = exp_load; e.addr = addr; e.chk_load = chk_load; e.fail = fail;
        if (c == 1'b0) sb0.push_back(e);
        else sb1.push_back(e);
        dREN[c] = ren; dWEN[c] = wen; datomic[c] = atm; daddr[c] = addr; dstore[c] = data;
        start = done_cnt[c];
        cyc = 0;
        while (done_cnt[c] == start && cyc < 100) begin
            @(posedge CLK);
            cyc++;
        end
        check($sformatf("op_completed_c%0d", c), 32'(done_cnt[c] - start), 32'd1);
        #1;
        dREN[c] = 1'b0; dWEN[c] = 1'b0; datomic[c] = 1'b0;
    endtask

    task automatic rd(input bit c, input word_t a, input word_t exp, output int cyc);
        op(c, 1'b1, 1'b0, 1'b0, a, '0, exp, 1'b1, 1'b0, cyc);
    endtask

    task automatic ll(input bit c, input word_t a, input word_t exp);
        int cyc;
        op(c, 1'b1, 1'b0, 1'b1, a, '0, exp, 1'b1, 1'b0, cyc);
    endtask

    task automatic wr(input bit c, input word_t a, input word_t d);
        int cyc;
        op(c, 1'b0, 1'b1, 1'b0, a, d, '0, 1'b0, 1'b0, cyc);
    endtask

    task automatic sc(input bit c, input word_t a, input word_t d, input bit ok, output int cyc);
        op(c, 1'b0, 1'b1, 1'b1, a, d, ok ? word_t'(1) : word_t'(0), 1'b1, !ok, cyc);
    endtask

    task automatic reset_dut();
        nRST = 1'b0;
        dREN = '0; dWEN = '0; datomic = '0; daddr = '0; dstore = '0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc, w0, s0, s1;
        exp_t e;
        ramstate = FREE; ramload = '0;
        mem[32'h100] = 32'hDEADBEEF;
        mem[32'h200] = 32'hAAAA0200;
        mem[32'h300] = 32'hBBBB0300;
        mem[32'h40]  = 32'h11;
        dREN = '0; dWEN = '0; datomic = '0; daddr = '0; dstore = '0;
        nRST = 1'b1;
        #1 nRST = 1'b0;
        #2;
        check("rst_dwait", 32'(dwait), 32'd3);
        check("rst_dload0", dload[0], 32'd0);
        check("rst_dload1", dload[1], 32'd0);
        check("rst_ram_en", 32'({ramREN, ramWEN}), 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_ramstore", ramstore, 32'd0);
        reset_dut();

        // Single read with two BUSY cycles.
        busy_n = 2;
        rd(1'b0, 32'h100, 32'hDEADBEEF, cyc);
        check("read_latency", 32'(cyc), 32'd4);
        busy_n = 0;

        // Both cores reading continuously: grants must alternate 0,1,0,1.
        reset_dut();
        for (int k = 0; k < 2; k++) begin
            e = '{load: 32'hAAAA0200, addr: 32'h200, chk_load: 1'b1, fail: 1'b0};
            sb0.push_back(e);
            e = '{load: 32'hBBBB0300, addr: 32'h300, chk_load: 1'b1, fail: 1'b0};
            sb1.push_back(e);
        end
        done_log.delete();
        s0 = done_cnt[0]; s1 = done_cnt[1];
        daddr[0] = 32'h200; daddr[1] = 32'h300;
        dREN = 2'b11;
        cyc = 0;
        while ((done_cnt[0] - s0 < 2 || done_cnt[1] - s1 < 2) && cyc < 100) begin
            @(posedge CLK);
            cyc++;
            #1;
            if (done_cnt[0] - s0 >= 2) dREN[0] = 1'b0;
            if (done_cnt[1] - s1 >= 2) dREN[1] = 1'b0;
        end
        dREN = 2'b00;
        check("alt_count", 32'(done_log.size()), 32'd4);
        for (int i = 0; i < done_log.size() && i < 4; i++)
            check($sformatf("alt_order_%0d", i), 32'(done_log[i]), 32'(i % 2));

        // LL then SC succeeds; the link is consumed so a second SC fails.
        ll(1'b0, 32'h40, 32'h11);
        sc(1'b0, 32'h40, 32'h5, 1'b1, cyc);
        check("sc_ok_latency", 32'(cyc), 32'd2);
        check("sc_ok_mem", mem[32'h40], 32'h5);
        sc(1'b0, 32'h40, 32'h6, 1'b0, cyc);
        check("sc_relink_fail_latency", 32'(cyc), 32'd2);

        // Neighbouring-word write keeps the link; same-word write clears it.
        ll(1'b0, 32'h40, 32'h5);
        wr(1'b1, 32'h44, 32'h7);
        sc(1'b0, 32'h40, 32'h6, 1'b1, cyc);
        check("sc_after_neighbour_mem", mem[32'h40], 32'h6);
        ll(1'b0, 32'h40, 32'h6);
        wr(1'b1, 32'h40, 32'h9);
        w0 = wr_cnt;
        sc(1'b0, 32'h40, 32'hA, 1'b0, cyc);
        check("scfail_no_write", 32'(wr_cnt), 32'(w0));
        check("scfail_mem_kept", mem[32'h40], 32'h9);

        // A read by the other core leaves the link intact.
        ll(1'b0, 32'h40, 32'h9);
        rd(1'b1, 32'h40, 32'h9, cyc);
        sc(1'b0, 32'h40, 32'hB, 1'b1, cyc);

        // Writer's own plain write clears its link.
        ll(1'b1, 32'h80, 32'h0);
        wr(1'b1, 32'h80, 32'h3);
        sc(1'b1, 32'h80, 32'h4, 1'b0, cyc);

        // Byte address inside the linked word still clears it.
        ll(1'b0, 32'h40, 32'hB);
        wr(1'b1, 32'h43, 32'h1);
        sc(1'b0, 32'h40, 32'hC, 1'b0, cyc);

        // SC without any prior LL.
        reset_dut();
        sc(1'b1, 32'h60, 32'h1, 1'b0, cyc);
        check("sc_nolink_latency", 32'(cyc), 32'd2);

        // ERROR three times then ACCESS: exactly one completion.
        err_n = 3;
        rd(1'b0, 32'h100, 32'hDEADBEEF, cyc);
        check("error_retry_latency", 32'(cyc), 32'd5);
        err_n = 0;

        // Reset while core 1 is mid-write.
        ll(1'b0, 32'h40, mem[32'h40]);
        ll(1'b1, 32'h500, 32'h0);
        busy_n = 20;
        w0 = wr_cnt;
        dWEN[1] = 1'b1; daddr[1] = 32'h500; dstore[1] = 32'h77;
        repeat (2) @(posedge CLK);
        #1;
        check("midserve_ramwen", 32'(ramWEN), 32'd1);
        check("midserve_dwait", 32'(dwait), 32'd3);
        nRST = 1'b0;
        #1;
        check("abort_ramwen", 32'(ramWEN), 32'd0);
        check("abort_ramaddr", ramaddr, 32'd0);
        check("abort_dwait", 32'(dwait), 32'd3);
        check("abort_dload1", dload[1], 32'd0);
        dWEN = '0;
        @(posedge CLK);
        #1 nRST = 1'b1;
        busy_n = 0;
        check("abort_no_write", 32'(wr_cnt), 32'(w0));
        sc(1'b0, 32'h40, 32'hD, 1'b0, cyc);
        sc(1'b1, 32'h500, 32'hE, 1'b0, cyc);

        repeat (3) @(posedge CLK);
        check("sb0_drained", 32'(sb0.size()), 32'd0);
        check("sb1_drained", 32'(sb1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
